// File: rtl/operand_issue_if.sv
// operand_issue_if: decode, register-cell, writeback and execute signals of the issue stage.
interface operand_issue_if #(parameter int WORD = 32, NREG = 32, RBITS = 5, CTRL = 8);
  logic                 dec_valid_i;
  logic                 dec_ready_o;
  logic [RBITS-1:0]     dec_rs1_i;
  logic [RBITS-1:0]     dec_rs2_i;
  logic [RBITS-1:0]     dec_rd_i;
  logic                 dec_we_i;
  logic [CTRL-1:0]      dec_ctrl_i;
  logic [NREG*WORD-1:0] reg_data_i;
  logic [NREG-1:0]      reg_reserved_i;
  logic [NREG-1:0]      w_reserve_o;
  logic                 wb_valid_i;
  logic [RBITS-1:0]     wb_addr_i;
  logic [WORD-1:0]      wb_data_i;
  logic                 ex_valid_o;
  logic                 ex_ready_i;
  logic [WORD-1:0]      ex_op1_o;
  logic [WORD-1:0]      ex_op2_o;
  logic [RBITS-1:0]     ex_rd_o;
  logic                 ex_we_o;
  logic [CTRL-1:0]      ex_ctrl_o;
  modport slave (
    input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_we_i, dec_ctrl_i,
    input  reg_data_i, reg_reserved_i, wb_valid_i, wb_addr_i, wb_data_i, ex_ready_i,
    output dec_ready_o, w_reserve_o, ex_valid_o, ex_op1_o, ex_op2_o, ex_rd_o, ex_we_o, ex_ctrl_o
  );
  modport master (
    output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_we_i, dec_ctrl_i,
    output reg_data_i, reg_reserved_i, wb_valid_i, wb_addr_i, wb_data_i, ex_ready_i,
    input  dec_ready_o, w_reserve_o, ex_valid_o, ex_op1_o, ex_op2_o, ex_rd_o, ex_we_o, ex_ctrl_o
  );
endinterface

// File: rtl/operand_issue.sv
// operand_issue: single-entry operand fetch/issue slot with writeback bypass and RAW/WAW hold.
module operand_issue #(parameter int WORD = 32, NREG = 32, RBITS = 5, CTRL = 8) (
  input logic clk,
  input logic rst,
  operand_issue_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, WAIT, READY} slot_t;
  slot_t st;
  logic valid, cap1, cap2, we;
  logic [RBITS-1:0] rs1, rs2, rd;
  logic [CTRL-1:0] ctrl;
  logic [WORD-1:0] op1, op2, val1, val2;
  logic [WORD-1:0] rf [NREG];
  logic byp1, byp2, av1, av2, wen, rd_free, fire, accept;
  for (genvar k = 0; k < NREG; k++) begin : g_rf
    assign rf[k] = bus.reg_data_i[k*WORD +: WORD];
  end
  always_comb begin
    byp1 = bus.wb_valid_i && bus.wb_addr_i == rs1;
    byp2 = bus.wb_valid_i && bus.wb_addr_i == rs2;
    av1 = cap1 || byp1 || !bus.reg_reserved_i[rs1];
    av2 = cap2 || byp2 || !bus.reg_reserved_i[rs2];
    val1 = cap1 ? op1 : byp1 ? bus.wb_data_i : rf[rs1];
    val2 = cap2 ? op2 : byp2 ? bus.wb_data_i : rf[rs2];
    wen = we && rd != '0;
    rd_free = !wen || !bus.reg_reserved_i[rd] || (bus.wb_valid_i && bus.wb_addr_i == rd);
    st = !valid ? EMPTY : (av1 && av2 && rd_free) ? READY : WAIT;
    fire = !rst && st == READY && (!bus.ex_valid_o || bus.ex_ready_i);
    bus.dec_ready_o = !valid || fire;
    accept = bus.dec_valid_i && bus.dec_ready_o;
    bus.w_reserve_o = (fire && wen) ? NREG'(1) << rd : '0;
  end
  // r0 sources are marked captured at accept with a zero value, so r0 is never looked up.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      cap1 <= 1'b0;
      cap2 <= 1'b0;
      we <= 1'b0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      ctrl <= '0;
      op1 <= '0;
      op2 <= '0;
      bus.ex_valid_o <= 1'b0;
      bus.ex_op1_o <= '0;
      bus.ex_op2_o <= '0;
      bus.ex_rd_o <= '0;
      bus.ex_we_o <= 1'b0;
      bus.ex_ctrl_o <= '0;
    end else begin
      if (accept) begin
        valid <= 1'b1;
        rs1 <= bus.dec_rs1_i;
        rs2 <= bus.dec_rs2_i;
        rd <= bus.dec_rd_i;
        we <= bus.dec_we_i;
        ctrl <= bus.dec_ctrl_i;
        cap1 <= bus.dec_rs1_i == '0;
        cap2 <= bus.dec_rs2_i == '0;
        op1 <= '0;
        op2 <= '0;
      end else if (fire) begin
        valid <= 1'b0;
      end else if (valid) begin
        if (!cap1 && av1) begin
          cap1 <= 1'b1;
          op1 <= val1;
        end
        if (!cap2 && av2) begin
          cap2 <= 1'b1;
          op2 <= val2;
        end
      end
      if (fire) begin
        bus.ex_valid_o <= 1'b1;
        bus.ex_op1_o <= val1;
        bus.ex_op2_o <= val2;
        bus.ex_rd_o <= rd;
        bus.ex_we_o <= wen;
        bus.ex_ctrl_o <= ctrl;
      end else if (bus.ex_ready_i) begin
        bus.ex_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Single-entry operand-fetch/issue stage between decode and execute.
- Reads data and write-reserve bits from the NREG register cells.
- Captures source operands, either directly or via same-cycle writeback bypass.
- Holds the instruction until RAW/WAW hazards clear, then issues it to execute and pulses the destination cell's write-reserve input.

Parameters:
- WORD, 32, data width.
- NREG, 32, number of register cells.
- RBITS, 5, register address width (log2 NREG).
- CTRL, 8, opaque control bits passed through to execute.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- dec_valid_i  in  1  decoded instruction valid
- dec_ready_o  out  1  stage can accept the instruction
- dec_rs1_i  in  RBITS  source 1 address
- dec_rs2_i  in  RBITS  source 2 address
- dec_rd_i  in  RBITS  destination address
- dec_we_i  in  1  instruction writes rd
- dec_ctrl_i  in  CTRL  passthrough control
- reg_data_i  in  NREG*WORD  flattened data outputs of the cells; reg k at bits [k*WORD +: WORD]
- reg_reserved_i  in  NREG  write-reserved bits of the cells
- w_reserve_o  out  NREG  one-hot reserve pulse to the cells
- wb_valid_i  in  1  writeback this cycle (same signal the cells see)
- wb_addr_i  in  RBITS  writeback address
- wb_data_i  in  WORD  writeback data
- ex_valid_o  out  1  issued instruction valid
- ex_ready_i  in  1  execute accepts
- ex_op1_o  out  WORD  operand 1
- ex_op2_o  out  WORD  operand 2
- ex_rd_o  out  RBITS  destination
- ex_we_o  out  1  write enable
- ex_ctrl_o  out  CTRL  control

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears all state:
  - Slot empty; dec_ready_o=1 after reset.
  - ex_valid_o=0, ex_op1_o/ex_op2_o=0, ex_rd_o=0, ex_we_o=0, ex_ctrl_o=0.
  - w_reserve_o=0 while rst=1.
  - Reset mid-operation drops the slot and output contents. No reserve pulse is issued for a dropped instruction.
- Slot states:
  - EMPTY.
  - WAIT: instruction held, an operand is missing or rd is busy.
  - READY: all operands captured or available this cycle, rd free.
  - Transitions are evaluated each cycle from the slot contents.
- Accept: dec_valid_i & dec_ready_o, where dec_ready_o = slot_empty | issue_fire. Accepted fields load into the slot at the edge.
- Register 0:
  - Reads as zero; r0 sources count as captured at accept.
  - we=1 with rd=0 is treated as we=0: no reserve pulse, no WAW check.
- Operand availability for source s (per cycle, while not yet captured), in priority order:
  1. wb_valid_i & wb_addr_i==rs → wb_data_i (bypass).
  2. Else if ~reg_reserved_i[rs] → reg_data_i slice.
  3. Else unavailable.
- An available operand latches into the slot at the edge and stays captured.
- rd free = ~we | rd==0 | ~reg_reserved_i[rd] | (wb_valid_i & wb_addr_i==rd).
- issue_fire = slot valid & both operands captured-or-available & rd free & (~ex_valid_o | ex_ready_i).
- On issue_fire:
  - Output registers load the effective operands, rd, we, ctrl.
  - ex_valid_o=1 next cycle.
  - Slot becomes empty, or loads a simultaneous new accept.
- w_reserve_o[rd] = issue_fire & we & rd!=0, combinational in the issue cycle. The cell therefore shows reserved in the following cycle, when the next slot instruction evaluates.
- Simultaneous reserve and writeback to the same rd: the cell gives reserve priority. The old data is dropped; this is correct because the new writer owns rd.
- Output handshake:
  - ex_valid_o clears after ex_valid_o & ex_ready_i unless issue_fire refills it.
  - Outputs hold stable while ex_valid_o & ~ex_ready_i.
- Latency: accept at edge t, operands ready → ex_valid_o in cycle t+2. Sustained throughput is 1 instruction/cycle with no hazards.

Test Plan:
- Reset then accept rs1=3, rs2=4, rd=5, we=1 with r3=0x11, r4=0x22 unreserved → ex_op1=0x11, ex_op2=0x22 two cycles later; w_reserve_o=0x20 for exactly one cycle.
- RAW: back-to-back rd=5 then rs1=5; wb r5=0xABCD arrives 3 cycles later → second instruction waits in WAIT, captures 0xABCD via bypass in the wb cycle, and issues next edge.
- WAW: r7 reserved, new instr rd=7 → no issue and no reserve pulse until wb to r7; reserve pulse occurs in the same cycle as that wb.
- Backpressure: ex_ready_i=0 for 4 cycles with 3 instrs queued → outputs stable, dec_ready_o=0 after the slot fills, no lost or duplicated instr, order preserved.
- r0 handling: rs1=0, rd=0, we=1 → op1=0, w_reserve_o stays 0, no stall even if reg_reserved_i[0]=1.
- Reset asserted while WAIT with an instruction pending → next cycle ex_valid_o=0, dec_ready_o=1, w_reserve_o=0.
